// File: rtl/ft245_rx_reader_if.sv
// Interface bundle for the FT245 receive reader: FT245 pins and the byte output handshake.
// Optional macro: FT245_RX_COUNT_EN adds the rx_count accepted-byte counter.
// master = the reader; slave = the FT245 pins and the byte consumer seen from the other side.
interface ft245_rx_reader_if;
    logic        rxf_n_245;
    logic        rd_n_245;
    logic [7:0]  d_245;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
`ifdef FT245_RX_COUNT_EN
    logic [15:0] rx_count;

    modport master (
        input  rxf_n_245, d_245, rx_ready,
        output rd_n_245, rx_data, rx_valid, rx_count
    );
    modport slave (
        output rxf_n_245, d_245, rx_ready,
        input  rd_n_245, rx_data, rx_valid, rx_count
    );
`else
    modport master (
        input  rxf_n_245, d_245, rx_ready,
        output rd_n_245, rx_data, rx_valid
    );
    modport slave (
        output rxf_n_245, d_245, rx_ready,
        input  rd_n_245, rx_data, rx_valid
    );
`endif
endinterface

// File: rtl/ft245_rx_reader.sv
// Drives the FT245 RD# strobe from a synchronised RXF# and hands each byte out on valid/ready.
// Latency: SYNC_STAGES+1 clks from RXF# low to RD# low, byte valid RD_LOW_CLKS clks after that.
// Backpressure: no new strobe while a byte is held unconsumed; the FT245 buffers meanwhile.
// Optional macro FT245_RX_COUNT_EN adds a 16-bit wrapping count of accepted bytes.
module ft245_rx_reader #(
    parameter int RD_LOW_CLKS  = 4,
    parameter int RD_HIGH_CLKS = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    ft245_rx_reader_if.master   bus
);

    localparam int REC_CLKS = RD_HIGH_CLKS + SYNC_STAGES;
    localparam int CNT_MAX  = (RD_LOW_CLKS > REC_CLKS) ? RD_LOW_CLKS : REC_CLKS;
    localparam int CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CW-1:0] LOW_LOAD = CW'(RD_LOW_CLKS - 1);
    localparam logic [CW-1:0] REC_LOAD = CW'(REC_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   rd_n, rd_n_nxt;
    logic [7:0]             data, data_nxt;
    logic                   valid, valid_nxt;
    logic [SYNC_STAGES-1:0] rxf_sync;
    logic                   rxf_s;

    // RXF# is asynchronous; resetting to 1 reads as "FIFO empty" until the chain fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxf_sync <= '1;
        end else begin
            rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], bus.rxf_n_245};
        end
    end

    assign rxf_s = rxf_sync[SYNC_STAGES-1];

    // State, strobe counter, RD# and the output byte register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rd_n  <= 1'b1;
            data  <= 8'h00;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rd_n  <= rd_n_nxt;
            data  <= data_nxt;
            valid <= valid_nxt;
        end
    end

    // Next-state: start a strobe only when the output slot is empty, capture at the end of RD# low,
    // then hold RD# high long enough for the FT245 and for stale RXF# to leave the synchroniser.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_n_nxt  = rd_n;
        data_nxt  = data;
        valid_nxt = valid;

        if (valid && bus.rx_ready) begin
            valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                rd_n_nxt = 1'b1;
                // valid here is the pre-clear value, so a consume and a start never share an edge.
                if (!rxf_s && !valid) begin
                    rd_n_nxt  = 1'b0;
                    cnt_nxt   = LOW_LOAD;
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                // RXF# is not looked at here: once started, the read always completes.
                if (cnt == '0) begin
                    data_nxt  = bus.d_245;
                    valid_nxt = 1'b1;
                    rd_n_nxt  = 1'b1;
                    cnt_nxt   = REC_LOAD;
                    state_nxt = RECOVER;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RECOVER: begin
                rd_n_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                rd_n_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.rd_n_245 = rd_n;
    assign bus.rx_data  = data;
    assign bus.rx_valid = valid;

`ifdef FT245_RX_COUNT_EN
    logic [15:0] acc_cnt;

    // Count accepted handshakes; natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= 16'h0000;
        end else if (valid && bus.rx_ready) begin
            acc_cnt <= acc_cnt + 16'h0001;
        end
    end

    assign bus.rx_count = acc_cnt;
`endif

endmodule

// File: doc/ft245_rx_reader.md
Name: ft245_rx_reader

Overview:
- Upstream receive stage between the FT245 USB FIFO pins and the sample FIFO of the transmitter.
- Runs the FT245 asynchronous read strobe (RD#) from the RXF# flag.
- Captures each byte and presents it on a valid/ready simple interface to the data FIFO write port.
- Read-only: the data bus is an input here; tristate and TX handling stay in the top level.

Parameters:
- RD_LOW_CLKS, 4, clk cycles RD# is held low before data capture (>=1).
- RD_HIGH_CLKS, 3, minimum clk cycles RD# is held high between reads (>=1).
- SYNC_STAGES, 2, flip-flop stages synchronising rxf_n_245 (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rxf_n_245  input  1  FT245 RXF#, low = byte available; asynchronous.
- rd_n_245  output  1  FT245 RD#, registered, active low.
- d_245  input  8  FT245 data bus (read direction).
- rx_data  output  8  captured byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready at a rising edge.

Behaviour:
- Reset (rst high at an edge):
  - rd_n_245=1, rx_valid=0, rx_data=8'h00.
  - State IDLE, counter=0, all sync flops=1 (RXF# inactive).
- Synchroniser:
  - rxf_s = last stage of the SYNC_STAGES chain.
  - Only rxf_s is used by the FSM.
  - d_245 is never synchronised; it is stable while RD# is low.
- IDLE:
  - Condition: rxf_s==0 and rx_valid==0.
  - At the next edge: rd_n_245<=0, counter<=RD_LOW_CLKS-1, go STROBE.
  - Otherwise stay in IDLE with rd_n_245=1.
- STROBE:
  - counter decrements each cycle.
  - At the edge where counter==0: rx_data<=d_245, rx_valid<=1, rd_n_245<=1, counter<=RD_HIGH_CLKS+SYNC_STAGES-1, go RECOVER.
  - RD# is therefore low for exactly RD_LOW_CLKS cycles.
- RECOVER:
  - counter decrements; at counter==0 go IDLE.
  - The extra SYNC_STAGES cycles flush the stale RXF# value from the synchroniser.
  - RD# is high for at least RD_HIGH_CLKS+SYNC_STAGES cycles between strobes.
- Output handshake:
  - rx_valid stays high and rx_data stays stable until an edge with rx_ready=1; then rx_valid<=0.
  - rx_ready while rx_valid=0 is ignored.
- Backpressure:
  - A new strobe starts only when rx_valid==0, so a byte is never overwritten.
  - The FT245 buffers while rx_ready is low.
- Simultaneous events:
  - Consumption and an IDLE start never coincide; IDLE samples rx_valid before the clear takes effect.
  - Next strobe starts at the edge after rx_valid falls, if rxf_s==0.
- RXF# rising during STROBE is ignored; the read completes.
- Reset mid-STROBE:
  - rd_n_245 returns high at the reset edge and rx_valid=0.
  - The byte being read is dropped (the FT245 advances on RD# rising). This loss is accepted.
- Throughput: one byte per RD_LOW_CLKS+RD_HIGH_CLKS+SYNC_STAGES+1 cycles minimum, with rx_ready tied high.

Optional Feature:
- Macro: FT245_RX_COUNT_EN.
- Defined:
  - Adds output rx_count [15:0], reset 0.
  - Increments by 1 at every accepted handshake (rx_valid & rx_ready); wraps 16'hFFFF -> 0.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan (RD_LOW_CLKS=4, RD_HIGH_CLKS=3, SYNC_STAGES=2, rx_ready=1 unless stated):
- Single byte: d_245=8'hA5, drive rxf_n_245 low.
  - rd_n_245 low exactly 4 cycles.
  - rx_data=8'hA5 with rx_valid high for 1 cycle at the edge rd_n_245 rises.
- Burst: rxf_n_245 held low, bytes 8'h01..8'h10.
  - 16 bytes received in order.
  - RD# high >=5 cycles between strobes; strobe period exactly 10 cycles.
- Backpressure: rx_ready=0 for 20 cycles with rxf_n_245 low.
  - One byte held stable, rd_n_245 stays high.
  - After rx_ready=1, the next strobe starts at the edge after rx_valid falls.
- Empty: rxf_n_245 high for 100 cycles -> rd_n_245 stays 1, rx_valid stays 0.
- Reset mid-strobe: assert rst in the 2nd RD#-low cycle.
  - rd_n_245=1, rx_valid=0 after that edge.
  - Normal reads resume after rst is released.
- FT245_RX_COUNT_EN defined: 65537 accepted bytes -> rx_count=16'h0001 (wrapped).
